switch_debounce: RTL

- Per-bit debouncer and edge detector for front-panel toggle and momentary switches.
- Sits directly downstream of the clk-domain synchroniser delay chain and consumes its data_out vector.
- Outputs a stable switch vector plus one-cycle rise/fall strobes for the front-panel control logic (EXAMINE, DEPOSIT, RUN/STOP, address/data switches).

---
 rtl/switch_debounce_if.sv | 30 +++
 rtl/switch_debounce.sv | 115 +++++++++++
 2 files changed

// File: rtl/switch_debounce_if.sv
// Switch-panel bundle between the synchroniser chain and the front-panel logic.
// master drives sample tick and raw levels; slave returns debounced levels and strobes.
interface switch_debounce_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  ce;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;
  logic                  changed;

  modport master (
    output ce,
    output data_in,
    input  data_out,
    input  rise,
    input  fall,
    input  changed
  );

  modport slave (
    input  ce,
    input  data_in,
    output data_out,
    output rise,
    output fall,
    output changed
  );
endinterface

// File: rtl/switch_debounce.sv
// Per-bit switch debouncer with registered rise/fall/changed strobes (auto-repeat: SWITCH_DEBOUNCE_AUTOREPEAT_EN).
// Latency: DEBOUNCE_CYCLES ce-qualified edges from a clean level change to data_out/strobe.
// No backpressure: strobes are single-cycle and must be consumed when asserted.
module switch_debounce #(
  parameter int                    DATA_WIDTH      = 16,
  parameter int                    CNT_WIDTH       = 16,
  parameter int                    DEBOUNCE_CYCLES = 50000,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter int                    REPEAT_CYCLES   = 250000
) (
  input  logic             clk,
  input  logic             reset,
  switch_debounce_if.slave sw
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Reject configurations that would make the counter compare unreachable.
  if ((DEBOUNCE_CYCLES < 1) || (64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_WIDTH)) ||
      (REPEAT_CYCLES < 1)) begin : g_param_err
    $error("switch_debounce: DEBOUNCE_CYCLES/REPEAT_CYCLES out of range");
  end

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] rise_q, rise_d;
  logic [DATA_WIDTH-1:0] fall_q, fall_d;
  logic                  changed_q, changed_d;
  logic [CNT_WIDTH-1:0]  cnt_q [DATA_WIDTH];
  logic [CNT_WIDTH-1:0]  cnt_d [DATA_WIDTH];

`ifdef SWITCH_DEBOUNCE_AUTOREPEAT_EN
  localparam logic [31:0] RPT_LAST = 32'(REPEAT_CYCLES - 1);

  logic [31:0] rpt_q [DATA_WIDTH];
  logic [31:0] rpt_d [DATA_WIDTH];
`endif

  always_comb begin
    data_out_d = data_out_q;
    rise_d     = '0;
    fall_d     = '0;
    cnt_d      = cnt_q;

    for (int i = 0; i < DATA_WIDTH; i++) begin
      // Any sample agreeing with the stable level restarts qualification.
      if (sw.data_in[i] == data_out_q[i]) begin
        cnt_d[i] = '0;
      end else if (sw.ce) begin
        if (cnt_q[i] == CNT_LAST) begin
          data_out_d[i] = sw.data_in[i];
          cnt_d[i]      = '0;
          rise_d[i]     = sw.data_in[i];
          fall_d[i]     = ~sw.data_in[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end

`ifdef SWITCH_DEBOUNCE_AUTOREPEAT_EN
    rpt_d = rpt_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      // Repeat timing restarts on any genuine edge and only runs while held high and settled.
      if ((data_out_d[i] != data_out_q[i]) || !data_out_q[i]) begin
        rpt_d[i] = '0;
      end else if (sw.ce && (cnt_q[i] == '0)) begin
        if (rpt_q[i] == RPT_LAST) begin
          rpt_d[i]  = '0;
          rise_d[i] = 1'b1;
        end else begin
          rpt_d[i] = rpt_q[i] + 32'd1;
        end
      end
    end
`endif

    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= RESET_VALUE;
      rise_q     <= '0;
      fall_q     <= '0;
      changed_q  <= 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      data_out_q <= data_out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      changed_q  <= changed_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef SWITCH_DEBOUNCE_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        rpt_q[i] <= '0;
      end
    end else begin
      rpt_q <= rpt_d;
    end
  end
`endif

  assign sw.data_out = data_out_q;
  assign sw.rise     = rise_q;
  assign sw.fall     = fall_q;
  assign sw.changed  = changed_q;

endmodule
